param_datapath: RTL and testbench

- Parametrised successor to the single-accumulator datapath; generalised data/opcode widths and a real ALU.
- Holds PC, IR, accumulator and Z/N/C flags; one internal system bus driven from one selected source.
- Tri-state bus drivers replaced by a one-hot-free encoded source select, so the bus never floats or contends.
- Sits between the control FSM (drives load/select strobes, consumes Opcode/flags) and the memory interface (Data_in).

---
 rtl/param_datapath_pkg.sv | 34 +++
 rtl/param_datapath_alu.sv | 37 +++
 rtl/param_datapath.sv | 130 +++++++++++++
 tb/tb_param_datapath.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/param_datapath_pkg.sv
// Shared encodings for the parametrised single-accumulator datapath.
// Data and opcode widths stay module parameters; only control encodings live here.
package param_datapath_pkg;

    localparam int unsigned ALU_OP_W  = 3;
    localparam int unsigned BUS_SEL_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_PASS = 3'd0,
        ALU_ADD  = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_INC  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_op_e;

    typedef enum logic [BUS_SEL_W-1:0] {
        BUS_OPERAND = 2'd0,
        BUS_PC      = 2'd1,
        BUS_ACC     = 2'd2,
        BUS_DATA    = 2'd3
    } bus_sel_e;

    // Only arithmetic ops report a carry; PASS and logic ops clear it.
    function automatic logic op_has_carry(input alu_op_e op);
        case (op)
            ALU_ADD, ALU_SUB, ALU_INC, ALU_SHL: op_has_carry = 1'b1;
            default:                            op_has_carry = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/param_datapath_alu.sv
// Combinational ALU: WIDTH+1-bit internal result, low WIDTH bits plus carry out.
// SUB computes a - b as a + ~b + 1, so the carry is the not-borrow flag.
module param_alu
    import param_datapath_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    localparam int unsigned EXT_W = WIDTH + 1;

    logic [WIDTH:0] full;

    always_comb begin
        full = '0;
        case (op)
            ALU_PASS: full = {1'b0, b};
            ALU_ADD:  full = {1'b0, a} + {1'b0, b};
            ALU_SUB:  full = {1'b0, a} + {1'b0, ~b} + EXT_W'(1);
            ALU_AND:  full = {1'b0, a & b};
            ALU_OR:   full = {1'b0, a | b};
            ALU_XOR:  full = {1'b0, a ^ b};
            ALU_INC:  full = {1'b0, a} + EXT_W'(1);
            ALU_SHL:  full = {a, 1'b0};
            default:  full = '0;
        endcase
    end

    assign result = full[WIDTH-1:0];
    assign carry  = op_has_carry(op) & full[WIDTH];

endmodule

// File: rtl/param_datapath.sv
// Parametrised accumulator datapath: PC, IR, Acc, Z/N/C flags around one muxed system bus.
// Optional macro DP_RELBRANCH_EN enables PC-relative loads (PC + SysBus) when PcRel is set.
module param_datapath
    import param_datapath_pkg::*;
#(
    parameter int unsigned      WIDTH        = 16,
    parameter int unsigned      OPC_W        = 4,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter bit               SEXT_OPERAND = 1'b0
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] Data_in,
    input  logic             SelInc,
    input  logic             LoadPC,
    input  logic             LoadIR,
    input  logic             LoadAcc,
    input  logic [2:0]       AluOp,
    input  logic [1:0]       BusSel,
    input  logic             BusEn,
    input  logic             PcRel,
    output logic [WIDTH-1:0] SysBus,
    output logic [OPC_W-1:0] Opcode,
    output logic             Zflag,
    output logic             Nflag,
    output logic             Cflag
);

    localparam int unsigned OPR_W = WIDTH - OPC_W;

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] acc_q;
    logic             z_q;
    logic             n_q;
    logic             c_q;

    logic [WIDTH-1:0] operand;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;

    // Operand field of IR widened to the bus width.
    always_comb begin
        if (SEXT_OPERAND) begin
            operand = {{OPC_W{ir_q[OPR_W-1]}}, ir_q[OPR_W-1:0]};
        end else begin
            operand = {{OPC_W{1'b0}}, ir_q[OPR_W-1:0]};
        end
    end

    // Encoded bus mux; a disabled bus reads as zero rather than floating.
    always_comb begin
        bus = '0;
        if (BusEn) begin
            case (bus_sel_e'(BusSel))
                BUS_OPERAND: bus = operand;
                BUS_PC:      bus = pc_q;
                BUS_ACC:     bus = acc_q;
                BUS_DATA:    bus = Data_in;
                default:     bus = '0;
            endcase
        end
    end

    assign SysBus = bus;

    param_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .a      (acc_q),
        .b      (bus),
        .op     (alu_op_e'(AluOp)),
        .result (alu_res),
        .carry  (alu_carry)
    );

    // PC source: increment, absolute bus load, or (optionally) bus-relative.
    always_comb begin
        pc_next = pc_q;
        if (LoadPC) begin
            if (SelInc) begin
                pc_next = pc_q + WIDTH'(1);
            end
`ifdef DP_RELBRANCH_EN
            else if (PcRel) begin
                pc_next = pc_q + bus;
            end
`endif
            else begin
                pc_next = bus;
            end
        end
    end

`ifndef DP_RELBRANCH_EN
    logic unused_pcrel;
    assign unused_pcrel = PcRel;
`endif

    // Reset outranks every load strobe issued in the same cycle.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            pc_q  <= RESET_PC;
            ir_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b1;
            n_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (LoadIR) begin
                ir_q <= bus;
            end
            if (LoadAcc) begin
                acc_q <= alu_res;
                z_q   <= (alu_res == '0);
                n_q   <= alu_res[WIDTH-1];
                c_q   <= alu_carry;
            end
        end
    end

    assign Opcode = ir_q[WIDTH-1 -: OPC_W];
    assign Zflag  = z_q;
    assign Nflag  = n_q;
    assign Cflag  = c_q;

endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (WIDTH=16, OPC_W=4, RESET_PC=0100, zero-extended operand).
// An arithmetic reference model is compared every cycle; directed literals pin the model.
module tb_param_datapath;

    localparam logic [15:0] RST_PC = 16'h0100;
`ifdef DP_RELBRANCH_EN
    localparam bit REL = 1'b1;
`else
    localparam bit REL = 1'b0;
`endif

    logic        clk;
    logic        Reset;
    logic [15:0] Data_in;
    logic        SelInc, LoadPC, LoadIR, LoadAcc, BusEn, PcRel;
    logic [2:0]  AluOp;
    logic [1:0]  BusSel;
    logic [15:0] SysBus;
    logic [3:0]  Opcode;
    logic        Zflag, Nflag, Cflag;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    param_datapath #(
        .WIDTH        (16),
        .OPC_W        (4),
        .RESET_PC     (RST_PC),
        .SEXT_OPERAND (1'b0)
    ) dut (
        .Clock   (clk),
        .Reset   (Reset),
        .Data_in (Data_in),
        .SelInc  (SelInc),
        .LoadPC  (LoadPC),
        .LoadIR  (LoadIR),
        .LoadAcc (LoadAcc),
        .AluOp   (AluOp),
        .BusSel  (BusSel),
        .BusEn   (BusEn),
        .PcRel   (PcRel),
        .SysBus  (SysBus),
        .Opcode  (Opcode),
        .Zflag   (Zflag),
        .Nflag   (Nflag),
        .Cflag   (Cflag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference model state
    logic [15:0] m_pc, m_ir, m_acc;
    logic        m_z, m_n, m_c;
    bit          started = 1'b0;

    function automatic logic [15:0] model_bus();
        if (!BusEn) return 16'h0000;
        case (BusSel)
            2'd0:    return m_ir & 16'h0FFF;
            2'd1:    return m_pc;
            2'd2:    return m_acc;
            default: return Data_in;
        endcase
    endfunction

    // Returns {carry, result} from plain integer arithmetic.
    function automatic logic [16:0] model_alu(input logic [2:0] op, input logic [15:0] a,
                                              input logic [15:0] b);
        int unsigned s;
        case (op)
            3'd0: return {1'b0, b};
            3'd1: begin s = a + b; return {s >= 32'd65536, s[15:0]}; end
            3'd2: begin s = a - b; return {a >= b, s[15:0]}; end
            3'd3: return {1'b0, a & b};
            3'd4: return {1'b0, a | b};
            3'd5: return {1'b0, a ^ b};
            3'd6: begin s = a + 1; return {s >= 32'd65536, s[15:0]}; end
            default: begin s = a * 2; return {s >= 32'd65536, s[15:0]}; end
        endcase
    endfunction

    function automatic logic [15:0] model_pc_next(input logic [15:0] b);
        if (!LoadPC) return m_pc;
        if (SelInc) return 16'(m_pc + 16'd1);
        if (REL && PcRel) return 16'(m_pc + b);
        return b;
    endfunction

    always @(posedge clk) begin
        logic [16:0] r;
        r = model_alu(AluOp, m_acc, model_bus());
        if (Reset) begin
            m_pc  <= RST_PC;
            m_ir  <= 16'h0000;
            m_acc <= 16'h0000;
            m_z   <= 1'b1;
            m_n   <= 1'b0;
            m_c   <= 1'b0;
        end else begin
            m_pc <= model_pc_next(model_bus());
            if (LoadIR) m_ir <= model_bus();
            if (LoadAcc) begin
                m_acc <= r[15:0];
                m_z   <= (r[15:0] == 16'h0000);
                m_n   <= r[15:0] >= 16'h8000;
                m_c   <= r[16];
            end
        end
        started <= 1'b1;
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (started) begin
            chk("bus", SysBus, model_bus());
            chk("opcode", {12'h000, Opcode}, {12'h000, m_ir[15:12]});
            chk("zflag", {15'h0, Zflag}, {15'h0, m_z});
            chk("nflag", {15'h0, Nflag}, {15'h0, m_n});
            chk("cflag", {15'h0, Cflag}, {15'h0, m_c});
        end
    end

    task automatic op(input logic lpc, input logic sinc, input logic lir, input logic lacc,
                      input logic [2:0] aop, input logic [1:0] bsel, input logic en,
                      input logic [15:0] din, input logic rel, input logic rst = 1'b0);
        LoadPC = lpc; SelInc = sinc; LoadIR = lir; LoadAcc = lacc;
        AluOp = aop; BusSel = bsel; BusEn = en; Data_in = din; PcRel = rel; Reset = rst;
        @(posedge clk);
        #1;
        LoadPC = 1'b0; LoadIR = 1'b0; LoadAcc = 1'b0; PcRel = 1'b0; SelInc = 1'b0; Reset = 1'b0;
    endtask

    task automatic peek(input logic [1:0] sel, input logic [15:0] exp, input string nm);
        BusSel = sel;
        BusEn  = 1'b1;
        #1;
        chk(nm, SysBus, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input logic z, input logic n, input logic c, input string nm);
        chk({nm, "_z"}, {15'h0, Zflag}, {15'h0, z});
        chk({nm, "_n"}, {15'h0, Nflag}, {15'h0, n});
        chk({nm, "_c"}, {15'h0, Cflag}, {15'h0, c});
    endtask

    initial begin
        Reset = 1'b1; Data_in = 16'hFFFF; SelInc = 1'b0; LoadPC = 1'b1; LoadIR = 1'b1;
        LoadAcc = 1'b1; AluOp = 3'd0; BusSel = 2'd3; BusEn = 1'b1; PcRel = 1'b0;
        @(posedge clk);
        #1;
        Reset = 1'b0; LoadPC = 1'b0; LoadIR = 1'b0; LoadAcc = 1'b0;

        // Reset values despite same-cycle loads
        peek(2'd1, 16'h0100, "reset_pc");
        peek(2'd2, 16'h0000, "reset_acc");
        chk("reset_opcode", {12'h000, Opcode}, 16'h0000);
        flags(1'b1, 1'b0, 1'b0, "reset");

        // Fetch and PC increment
        op(0, 0, 1, 0, 3'd0, 2'd3, 1, 16'hA123, 0);
        chk("fetch_opcode", {12'h000, Opcode}, 16'h000A);
        op(1, 1, 0, 0, 3'd0, 2'd1, 1, 16'h0000, 0);
        peek(2'd0, 16'h0123, "fetch_operand");
        peek(2'd1, 16'h0101, "pc_inc");

        // PC wrap
        op(1, 0, 0, 0, 3'd0, 2'd3, 1, 16'hFFFF, 0);
        op(1, 1, 0, 0, 3'd0, 2'd3, 1, 16'h0000, 0);
        peek(2'd1, 16'h0000, "pc_wrap");

        // ADD with carry out
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'hFFFF, 0);
        op(0, 0, 0, 1, 3'd1, 2'd3, 1, 16'h0001, 0);
        peek(2'd2, 16'h0000, "add_acc");
        flags(1'b1, 1'b0, 1'b1, "add");

        // SUB with borrow
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'h0005, 0);
        op(0, 0, 0, 1, 3'd2, 2'd3, 1, 16'h0007, 0);
        peek(2'd2, 16'hFFFE, "sub_acc");
        flags(1'b0, 1'b1, 1'b0, "sub");

        // XOR with itself via acc on the bus
        op(0, 0, 0, 1, 3'd5, 2'd2, 1, 16'h0000, 0);
        peek(2'd2, 16'h0000, "xor_acc");
        flags(1'b1, 1'b0, 1'b0, "xor");

        // Old accumulator value is what the bus carries
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'h0003, 0);
        op(0, 0, 0, 1, 3'd1, 2'd2, 1, 16'h0000, 0);
        peek(2'd2, 16'h0006, "bus_order_acc");

        // Disabled bus loads zero
        op(0, 0, 1, 0, 3'd0, 2'd3, 0, 16'hA123, 0);
        chk("busen0_opcode", {12'h000, Opcode}, 16'h0000);
        peek(2'd0, 16'h0000, "busen0_operand");
        op(0, 0, 0, 1, 3'd0, 2'd2, 0, 16'h0000, 0);
        peek(2'd2, 16'h0000, "busen0_acc");

        // Relative branch request
        op(1, 0, 0, 0, 3'd0, 2'd3, 1, 16'h0010, 0);
        op(1, 0, 0, 0, 3'd0, 2'd3, 1, 16'hFFFC, 1);
        peek(2'd1, REL ? 16'h000C : 16'hFFFC, "pc_rel");
        op(1, 1, 0, 0, 3'd0, 2'd3, 1, 16'h4000, 1);
        peek(2'd1, REL ? 16'h000D : 16'hFFFD, "pc_rel_inc");

        // INC / SHL / AND / OR patterns
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'hFFFF, 0);
        op(0, 0, 0, 1, 3'd6, 2'd3, 1, 16'h0000, 0);
        peek(2'd2, 16'h0000, "inc_acc");
        flags(1'b1, 1'b0, 1'b1, "inc");
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'h8001, 0);
        op(0, 0, 0, 1, 3'd7, 2'd3, 1, 16'h0000, 0);
        peek(2'd2, 16'h0002, "shl_acc");
        flags(1'b0, 1'b0, 1'b1, "shl");
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'hF0F0, 0);
        op(0, 0, 0, 1, 3'd3, 2'd3, 1, 16'hFF00, 0);
        peek(2'd2, 16'hF000, "and_acc");
        op(0, 0, 0, 1, 3'd4, 2'd3, 1, 16'h000F, 0);
        peek(2'd2, 16'hF00F, "or_acc");
        flags(1'b0, 1'b1, 1'b0, "or");

        // Reset mid-operation discards same-cycle loads
        op(0, 0, 0, 1, 3'd0, 2'd3, 1, 16'h1234, 0);
        op(1, 0, 1, 1, 3'd1, 2'd3, 1, 16'h5555, 0, 1'b1);
        peek(2'd1, 16'h0100, "midreset_pc");
        peek(2'd2, 16'h0000, "midreset_acc");
        chk("midreset_opcode", {12'h000, Opcode}, 16'h0000);
        flags(1'b1, 1'b0, 1'b0, "midreset");

        @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
